// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for opb_register_bank_ppc2simulink.
// Signals keep OPB big-endian bit numbering ([0:31], bit 0 = MSB).
//   master modport : drives OPB_* request signals, samples Sl_* responses
//   slave modport  : samples OPB_* request signals, drives Sl_* responses
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB register bank: C_NUM_REGS software-writable 32-bit registers feeding
// user logic, each with a one-cycle update strobe and a readable 32-bit
// write counter. Byte-enable writes, full readback, errAck on unmapped words.
// Word map (relative to C_BASEADDR, 4 bytes per word):
//   0 .. N-1    user registers (R/W)
//   N .. 2N-1   write counters (RO, writes acked and ignored)
//   2N          commit word when OPB_REG_BANK_SHADOW_EN is defined, else unmapped
//   above       unmapped (xferAck + errAck, read data 0)
// Optional feature macro: OPB_REG_BANK_SHADOW_EN (staged writes + commit word).
// Ports:
//   OPB_Clk, OPB_Rst_n : clock, async active-low reset
//   opb                : OPB slave bus (interface, slave modport)
//   user_data_out      : register i at bits [32i+31:32i]
//   user_data_valid    : per-register one-cycle update strobe
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_01FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h0,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                             OPB_Clk,
  input  logic                             OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave  opb,
  output logic [32*C_NUM_REGS-1:0]         user_data_out,
  output logic [C_NUM_REGS-1:0]            user_data_valid
);
  localparam int N  = C_NUM_REGS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Unsupported geometry decodes nothing, so a bad build is obvious on the bus.
  localparam bit CFG_OK = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) &&
                          (N >= 1) && (N <= 16) &&
                          ((C_HIGHADDR - C_BASEADDR) >= 32'(4*(2*N+1) - 1));
  // Target family is informational only.
  localparam string unused_family = C_FAMILY;

  typedef enum logic {S_IDLE, S_ACK} state_t;
  typedef enum logic [1:0] {K_REG, K_CNT, K_CMT, K_ERR} kind_t;

  state_t                state_q;
  kind_t                 kind_q;
  logic [IW-1:0]         idx_q;
  logic                  rnw_q;
  logic                  xfer_q, err_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [N-1:0][31:0]    regs_q, cnt_q, rd_src;
  logic [N-1:0]          valid_q;
`ifdef OPB_REG_BANK_SHADOW_EN
  logic [N-1:0][31:0]    shadow_q;
  logic [N-1:0]          dirty_q;
`endif

  // Address decode
  logic [31:0] abus, off, widx, cidx, wdata;
  logic [3:0]  be;
  logic        hit, is_reg, is_cnt, is_cmt;

  assign abus   = opb.OPB_ABus;
  assign off    = abus - C_BASEADDR;
  assign widx   = {2'b00, off[31:2]};
  assign cidx   = widx - 32'(N);
  assign hit    = CFG_OK && opb.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign is_reg = widx < 32'(N);
  assign is_cnt = !is_reg && (widx < 32'(2*N));
  // Numeric copies keep MSB alignment: BE[0] lands on be[3], i.e. user byte 3.
  assign wdata  = opb.OPB_DBus;
  assign be     = opb.OPB_BE;

  logic unused_ok;
  assign unused_ok = &{1'b0, off[1:0], opb.OPB_seqAddr};

`ifdef OPB_REG_BANK_SHADOW_EN
  assign is_cmt = (widx == 32'(2*N));
  assign rd_src = shadow_q;   // register reads return the staged value
`else
  assign is_cmt = 1'b0;
  assign rd_src = regs_q;
`endif

  always_comb begin
    rdata_d = '0;
    if (opb.OPB_RNW) begin
      if (is_reg)      rdata_d = rd_src[widx[IW-1:0]];
      else if (is_cnt) rdata_d = cnt_q[cidx[IW-1:0]];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0]  ben);
    for (int k = 0; k < 4; k++)
      merge[8*k +: 8] = ben[k] ? wd[8*k +: 8] : old[8*k +: 8];
  endfunction

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      kind_q   <= K_ERR;
      idx_q    <= '0;
      rnw_q    <= 1'b1;
      xfer_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= '0;
      regs_q   <= {N{C_RESET_VAL}};
      cnt_q    <= '0;
`ifdef OPB_REG_BANK_SHADOW_EN
      shadow_q <= {N{C_RESET_VAL}};
      dirty_q  <= '0;
`endif
    end else begin
      xfer_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= '0;
      unique case (state_q)
        S_IDLE: if (hit) begin
          state_q <= S_ACK;
          xfer_q  <= 1'b1;
          err_q   <= !(is_reg || is_cnt || is_cmt);
          rdata_q <= rdata_d;
          rnw_q   <= opb.OPB_RNW;
          idx_q   <= widx[IW-1:0];
          kind_q  <= is_reg ? K_REG : is_cnt ? K_CNT : is_cmt ? K_CMT : K_ERR;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          // Write data/enables are sampled live; the master holds them through ack.
          if (!rnw_q) begin
            unique case (kind_q)
              K_REG: begin
`ifdef OPB_REG_BANK_SHADOW_EN
                shadow_q[idx_q] <= merge(shadow_q[idx_q], wdata, be);
                dirty_q[idx_q]  <= 1'b1;
`else
                regs_q[idx_q]   <= merge(regs_q[idx_q], wdata, be);
                cnt_q[idx_q]    <= cnt_q[idx_q] + 32'd1;
                valid_q[idx_q]  <= 1'b1;
`endif
              end
              K_CMT: begin
`ifdef OPB_REG_BANK_SHADOW_EN
                for (int i = 0; i < N; i++) begin
                  if (dirty_q[i]) begin
                    regs_q[i]  <= shadow_q[i];
                    cnt_q[i]   <= cnt_q[i] + 32'd1;
                    valid_q[i] <= 1'b1;
                  end
                end
                dirty_q <= '0;
`endif
              end
              default: ;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign opb.Sl_DBus     = rdata_q;
  assign opb.Sl_xferAck  = xfer_q;
  assign opb.Sl_errAck   = err_q;
  assign opb.Sl_retry    = 1'b0;
  assign opb.Sl_toutSup  = 1'b0;
  assign user_data_out   = regs_q;
  assign user_data_valid = valid_q;
endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised OPB slave exposing C_NUM_REGS software-writable 32-bit registers to user logic. Each register has its own single-cycle update strobe, which drives the *_in_val style handshakes into the DSP fabric.
Adds byte-enable writes, full readback, error acknowledge for unmapped words, and a per-register write counter readable over OPB.
Sits on the shared OPB bus. User logic runs on OPB_Clk, so there is no clock-domain crossing.

Parameters:
C_BASEADDR, 32'h01000100, first byte address of the bank
C_HIGHADDR, 32'h010001FF, last byte address decoded (window must be ≥ 4*(2*C_NUM_REGS+1) bytes)
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
C_NUM_REGS, 4, number of user registers, 1..16
C_RESET_VAL, 0, reset value applied to every user register (32 bits)
C_FAMILY, "virtex6", target family, informational

Ports:
OPB_Clk  in  1  bus and user clock
OPB_Rst_n  in  1  asynchronous active-low reset
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] maps to DBus[0:7], which is user bits [31:24]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  sequential burst hint; ignored, each beat is handled as a single transfer
Sl_DBus  out  [0:31]  read data; zero when not acknowledging
Sl_errAck  out  1  error acknowledge
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
user_data_out  out  32*C_NUM_REGS  register i occupies bits [32i+31:32i]
user_data_valid  out  C_NUM_REGS  one-cycle update strobe per register

Behaviour:
- Reset (async assert, sync deassert externally provided):
  - all registers = C_RESET_VAL
  - user_data_valid = 0, Sl_xferAck = 0, Sl_errAck = 0, Sl_DBus = 0
  - write counters = 0; FSM in IDLE
- Address decode:
  - hit = OPB_select && BASE ≤ ABus ≤ HIGH
  - word index w = (ABus − BASE) >> 2
- Address map:
  - w < C_NUM_REGS: user register w, read/write
  - C_NUM_REGS ≤ w < 2*C_NUM_REGS: write counter of register (w − C_NUM_REGS), read-only; writes ignored but acknowledged
  - w == 2*C_NUM_REGS, or ABus inside the window but beyond that word: unmapped
- FSM states:
  - IDLE → ACK on hit.
  - ACK lasts exactly one cycle: Sl_xferAck = 1. Then → IDLE.
  - Master must drop select on acknowledge. If select is still high in IDLE it is treated as a new transfer, so back-to-back beats are acknowledged every 2 cycles.
- Unmapped access: in ACK, assert Sl_errAck = 1 together with Sl_xferAck; read data = 0; write has no effect.
- Write, committed on the ACK cycle:
  - for each byte b with BE[b] = 1, register byte (3−b) ← DBus[8b:8b+7]
  - BE = 0000 still counts as a write
- Strobe and counter: on the cycle after the ACK of a mapped register write,
  - user_data_valid[w] = 1 for exactly one cycle
  - user_data_out already shows the new value on that same cycle
  - counter[w] increments by 1, 32-bit, wraps FFFFFFFF → 0
- Read: Sl_DBus is driven from a registered mux during ACK only and is 0 at all other times. Read latency is select-to-ack 1 cycle.
- Simultaneous events:
  - only one bus transfer is in flight at a time, so at most one valid bit is high per cycle
  - a read of counter k in the same ACK cycle as… not possible; the FSM serialises transfers
- Reset mid-transfer: ACK is aborted, no write is committed, no strobe is issued.
- OPB_Rst_n low forces the bus outputs to 0 immediately (asynchronous).

Optional Feature:
Macro OPB_REG_BANK_SHADOW_EN.
- Defined:
  - writes to register w land in shadow[w]; user_data_out does not change
  - a write of any value to word 2*C_NUM_REGS (the commit address, now mapped and not an error) copies every shadow that is dirty since the last commit into user_data_out
  - on the next cycle, user_data_valid pulses for all dirty registers simultaneously and their counters increment
  - register reads return the shadow value
  - reset clears shadows to C_RESET_VAL and clears the dirty bits
- Undefined: direct-write behaviour as above; word 2*C_NUM_REGS is unmapped (errAck).

Test Plan:
1. Reset, then read word 0..3 → each returns 0 (C_RESET_VAL), xferAck 1 cycle after select, errAck = 0.
2. Write 0xDEADBEEF, BE = 1111, to 0x01000104 → next cycle user_data_out[63:32] = DEADBEEF, user_data_valid = 0010 for one cycle; a read of 0x01000114 (counter 1) returns 1.
3. Write 0x11223344 with BE = 0100 to register 0, preloaded with 0xAAAAAAAA → register 0 = 0xAA22AAAA.
4. Read 0x01000120 and 0x010001FC (unmapped, C_NUM_REGS = 4) → xferAck and errAck both high, data 0, no strobe; then hold select high → second ack exactly 2 cycles after the first.
5. Assert OPB_Rst_n low during ACK of a write of 0x5 to register 2 → register 2 stays 0, no valid pulse, outputs 0 asynchronously.
6. With SHADOW_EN: write 7 → reg0 and 9 → reg3, then write to commit 0x01000120 → outputs unchanged until commit; then valid = 1001 in one cycle, counters 0 and 3 = 1; a second commit produces no strobe.
